// File: rtl/dpcm_channel_arbiter.sv
// Round-robin arbiter sharing one |x - prev| saturating DPCM engine across NCH channels.
// Each channel keeps its own history; results are tagged with the producing channel.
module dpcm_channel_arbiter #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int SAT = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*W-1:0]         in_data,
    output logic [NCH-1:0]           in_ready,
    input  logic [NCH-1:0]           clr_hist,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(NCH)-1:0]   out_chan,
    output logic                     busy
);

    localparam int CW = $clog2(NCH);
    localparam logic [W-1:0] SAT_W = W'(SAT);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cur_chan_q, cur_chan_d;
    logic [CW-1:0]  out_chan_q, out_chan_d;
    logic [W-1:0]   cur_data_q, cur_data_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   hist_q [NCH];
    logic [W-1:0]   hist_d [NCH];

    logic [CW-1:0]  grant;
    logic           grant_found;
    logic [W-1:0]   hist_sel;
    logic [W-1:0]   diff;

    // Scan offsets from the far end so the channel nearest rr_ptr wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (in_valid[(int'(rr_ptr_q) + k) % NCH]) begin
                grant       = CW'((int'(rr_ptr_q) + k) % NCH);
                grant_found = 1'b1;
            end
        end
    end

    assign hist_sel = hist_q[cur_chan_q];
    assign diff     = (cur_data_q >= hist_sel) ? (cur_data_q - hist_sel) : (hist_sel - cur_data_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_chan_d  = cur_chan_q;
        cur_data_d  = cur_data_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        hist_d      = hist_q;
        in_ready    = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    in_ready[grant] = 1'b1;
                    cur_data_d      = in_data[grant*W +: W];
                    cur_chan_d      = grant;
                    rr_ptr_d        = (grant == CW'(NCH - 1)) ? '0 : grant + 1'b1;
                    state_d         = CALC;
                end
            end
            CALC: begin
                out_data_d          = (diff > SAT_W) ? SAT_W : diff;
                out_chan_d          = cur_chan_q;
                out_valid_d         = 1'b1;
                hist_d[cur_chan_q]  = cur_data_q;
                state_d             = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear landing on the same edge as the CALC write takes priority.
        for (int i = 0; i < NCH; i++) begin
            if (clr_hist[i]) begin
                hist_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_chan_q  <= '0;
            cur_data_q  <= '0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_chan_q  <= cur_chan_d;
            cur_data_q  <= cur_data_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dpcm_channel_arbiter.sv
// Bench for dpcm_channel_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grants, per-channel history and saturation.
module tb_dpcm_channel_arbiter;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int SAT = 200;
    localparam int CW  = $clog2(NCH);

    logic                clk;
    logic                rst;
    logic [NCH-1:0]      in_valid;
    logic [NCH*W-1:0]    in_data;
    logic [NCH-1:0]      in_ready;
    logic [NCH-1:0]      clr_hist;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [CW-1:0]       out_chan;
    logic                busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: last sample per channel and the next channel to favour.
    int hist_m [NCH];
    int rr_m;

    dpcm_channel_arbiter #(.NCH(NCH), .W(W), .SAT(SAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr_hist  (clr_hist),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) hist_m[i] = 0;
        rr_m = 0;
    endtask

    function automatic int modelGrant(input logic [NCH-1:0] vmask);
        for (int k = 0; k < NCH; k++) begin
            if (vmask[(rr_m + k) % NCH]) return (rr_m + k) % NCH;
        end
        return -1;
    endfunction

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        clr_hist  = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
    endtask

    // One full transaction: offer vmask/data, clear clrm on the CALC edge, stall the
    // output for 'stall' cycles, then hand it off. Called at posedge+1 in IDLE.
    task automatic applyStimulus(input logic [NCH-1:0] vmask, input logic [NCH*W-1:0] data,
                                 input logic [NCH-1:0] clrm, input int stall,
                                 output logic [W-1:0] got_data, output logic [CW-1:0] got_chan);
        int g, d, h, diffv, expv;
        logic [NCH-1:0] onehot;
        in_valid  = vmask;
        in_data   = data;
        out_ready = 1'b0;
        g = modelGrant(vmask);
        onehot = '0;
        onehot[g] = 1'b1;
        #1;
        checkOutput("in_ready_grant", 32'(in_ready), 32'(onehot));
        checkOutput("busy_idle", 32'(busy), 32'd0);

        @(posedge clk); #1;
        checkOutput("busy_calc", 32'(busy), 32'd1);
        checkOutput("in_ready_calc", 32'(in_ready), 32'd0);
        clr_hist = clrm;

        @(posedge clk); #1;
        clr_hist = '0;
        d = int'(data[g*W +: W]);
        h = hist_m[g];
        diffv = (d > h) ? d - h : h - d;
        expv = (diffv > SAT) ? SAT : diffv;
        hist_m[g] = d;
        for (int i = 0; i < NCH; i++) if (clrm[i]) hist_m[i] = 0;
        rr_m = (g + 1) % NCH;
        checkOutput("out_valid_rise", 32'(out_valid), 32'd1);
        checkOutput("out_data", 32'(out_data), 32'(expv));
        checkOutput("out_chan", 32'(out_chan), 32'(g));
        got_data = out_data;
        got_chan = out_chan;

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_data", 32'(out_data), 32'(expv));
            checkOutput("stall_chan", 32'(out_chan), 32'(g));
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = '0;
        checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
        checkOutput("post_hs_busy", 32'(busy), 32'd0);
        checkOutput("post_hs_data_held", 32'(out_data), 32'(expv));
    endtask

    task automatic sendOne(input int ch, input int val, input logic [NCH-1:0] clrm, input int stall,
                           output logic [W-1:0] got_data, output logic [CW-1:0] got_chan);
        logic [NCH-1:0]   vm;
        logic [NCH*W-1:0] dv;
        vm = '0;
        vm[ch] = 1'b1;
        dv = {NCH*W{1'b1}};
        dv[ch*W +: W] = W'(val);
        applyStimulus(vm, dv, clrm, stall, got_data, got_chan);
    endtask

    initial begin
        logic [W-1:0]  gd;
        logic [CW-1:0] gc;
        logic [NCH-1:0] vm, cm;
        logic [NCH*W-1:0] dv;
        int gexp[5];

        doReset();

        // Reset asserted asynchronously while a result waits in OUT.
        in_valid  = 4'b0001;
        in_data   = 32'h0000_004D;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = '0;
        @(posedge clk); #1;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_chan", 32'(out_chan), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        in_valid = 4'b1111;
        #1;
        checkOutput("rst_rr_ptr_grant", 32'(in_ready), 32'b0001);
        in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        sendOne(0, 50, '0, 0, gd, gc);
        checkOutput("reset_first_data", 32'(gd), 32'd50);
        checkOutput("reset_first_chan", 32'(gc), 32'd0);

        // Difference and saturation on channel 1.
        doReset();
        sendOne(1, 10, '0, 0, gd, gc);
        checkOutput("ch1_s0", 32'(gd), 32'd10);
        sendOne(1, 250, '0, 0, gd, gc);
        checkOutput("ch1_s1_sat", 32'(gd), 32'd200);
        sendOne(1, 30, '0, 0, gd, gc);
        checkOutput("ch1_s2_sat", 32'(gd), 32'd200);
        sendOne(1, 30, '0, 0, gd, gc);
        checkOutput("ch1_s3_equal", 32'(gd), 32'd0);

        // Round robin with every channel requesting.
        doReset();
        gexp = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            applyStimulus(4'b1111, 32'h2814_0A05, '0, 0, gd, gc);
            checkOutput("rr_grant", 32'(gc), 32'(gexp[n]));
        end

        // Backpressure for five cycles.
        sendOne(2, 77, '0, 5, gd, gc);
        checkOutput("bp_chan", 32'(gc), 32'd2);

        // History clear colliding with the CALC write on channel 2.
        doReset();
        sendOne(2, 100, '0, 0, gd, gc);
        checkOutput("clr_first", 32'(gd), 32'd100);
        sendOne(2, 120, 4'b0100, 0, gd, gc);
        checkOutput("clr_collide", 32'(gd), 32'd20);
        sendOne(2, 40, '0, 0, gd, gc);
        checkOutput("clr_after", 32'(gd), 32'd40);

        // Channel isolation between ch0 and ch3.
        doReset();
        sendOne(0, 100, '0, 0, gd, gc);
        sendOne(3, 5, '0, 0, gd, gc);
        sendOne(0, 90, '0, 0, gd, gc);
        checkOutput("iso_ch0", 32'(gd), 32'd10);
        sendOne(3, 7, '0, 0, gd, gc);
        checkOutput("iso_ch3", 32'(gd), 32'd2);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            vm = NCH'($urandom_range(1, (1 << NCH) - 1));
            dv = $urandom;
            cm = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            applyStimulus(vm, dv, cm, $urandom_range(0, 3), gd, gc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpcm_channel_arbiter.md
# dpcm_channel_arbiter

Shares one absolute-difference-and-saturate DPCM engine among NCH independent sample channels. Each channel has its own valid/ready input port and its own previous-sample history. A round-robin scheduler grants one channel at a time. The block sits between the per-channel sample sources and a single downstream consumer, and tags every result with its channel number.

## Interface
- NCH, 4: number of requester channels (2..16)
- W, 8: sample and result width in bits
- SAT, 200: saturation ceiling for results; must be below 2^W
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  NCH  per-channel sample valid
- in_data  in  NCH*W  per-channel sample; channel i occupies bits [i*W +: W]
- in_ready  out  NCH  per-channel accept; at most one bit high
- clr_hist  in  NCH  per-channel synchronous history clear
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  W  saturated absolute difference
- out_chan  out  $clog2(NCH)  channel that produced out_data
- busy  out  1  high whenever state is not IDLE

## Operation
- State: hist[NCH] (W bits each), rr_ptr, cur_data, cur_chan, FSM state.
- FSM states: IDLE, CALC, OUT.
- **IDLE**
  - Grant g is the first channel with in_valid high, searching from rr_ptr upward with wrap.
  - in_ready[g] is driven combinationally high in IDLE only. All in_ready bits are 0 in CALC and OUT.
  - Sources must not make in_valid depend on in_ready.
  - When in_valid[g] and in_ready[g] are both high at a clock edge:
    - cur_data <= in_data[g]
    - cur_chan <= g
    - rr_ptr <= (g+1) mod NCH
    - state goes to CALC
  - If no channel is valid, remain in IDLE and hold rr_ptr.
- **CALC** (one cycle)
  - diff = |cur_data - hist[cur_chan]|, computed unsigned, W bits, with no wrap.
  - out_data <= (diff > SAT) ? SAT : diff
  - out_chan <= cur_chan
  - out_valid <= 1
  - hist[cur_chan] <= cur_data
  - state goes to OUT
- **OUT**
  - out_valid, out_data and out_chan hold stable until out_ready is high at an edge.
  - On that edge: out_valid <= 0 and state goes to IDLE.
  - out_data and out_chan keep their last values after the handshake.
- **History**
  - The first sample on a channel after reset or clear is compared against 0, so the result is min(sample, SAT).
  - Equal samples produce 0.
  - clr_hist[i] high at an edge sets hist[i] <= 0. It may be asserted in any state.
  - If clr_hist[cur_chan] coincides with the CALC write, the clear wins and hist becomes 0. out_data still uses the pre-clear hist value.
- **Reset** (asynchronous, any time, including mid-transaction)
  - state = IDLE, rr_ptr = 0, all hist = 0, cur_data = 0, cur_chan = 0.
  - out_valid = 0, out_data = 0, out_chan = 0, busy = 0.
  - in_ready follows the IDLE grant logic immediately after reset.
  - An in-flight sample is discarded and produces no output.

## Timing
- Accept edge T: the FSM enters CALC.
- Edge T+1: out_valid rises. Latency from accept to result visible is 1 cycle.
- Earliest output handshake is edge T+2. The next accept is at T+3 at the earliest, giving a peak throughput of 1 sample per 3 cycles.
- Each cycle out_ready stays low while out_valid is high adds one cycle.
- Fairness: a continuously valid channel waits at most NCH-1 grants.
- busy is high from edge T through the output-handshake edge.
- in_data on non-granted channels is ignored.

## Test plan
- **Reset defaults.** Assert rst asynchronously mid-OUT, then release. Required: out_valid=0, out_data=0, out_chan=0, busy=0, rr_ptr=0. A following sample 50 on ch0 yields out_data=50, out_chan=0.
- **Difference and saturation on ch1.** Send samples 10, 250, 30, 30. Required outputs: 10, 200 (saturated), 200 (220 saturated), 0.
- **Round robin.** With NCH=4, hold in_valid=4'b1111 with fixed data. Required: grants ch0, ch1, ch2, ch3, ch0, and exactly one in_ready bit high per accept.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid rises. Required: out_data and out_chan stable, and all in_ready bits 0 throughout. Accept resumes only after the handshake.
- **History clear collision.** On ch2, send sample 100, then send 120 with clr_hist[2] pulsed on the CALC edge. Required: second output = 20. A third sample of 40 then yields 40 (history was cleared).
- **Channel isolation.** ch0 receives 100 and ch3 receives 5, interleaved. Then send ch0=90 and ch3=7. Required: ch0 output 10 and ch3 output 2.
